// File: rtl/gzip_packet_arbiter_if.sv
// Stream bundle around the shared compressor: two raw byte requesters, compressor in/out, tagged output.
// slave is the arbiter's view; master is the surrounding environment's view.
interface gzip_packet_arbiter_if;
    logic        s0_tvalid;
    logic        s0_tready;
    logic [7:0]  s0_tdata;
    logic        s0_tlast;

    logic        s1_tvalid;
    logic        s1_tready;
    logic [7:0]  s1_tdata;
    logic        s1_tlast;

    logic        c_tvalid;
    logic        c_tready;
    logic [7:0]  c_tdata;
    logic        c_tlast;

    logic        z_tvalid;
    logic        z_tready;
    logic [31:0] z_tdata;
    logic [3:0]  z_tkeep;
    logic        z_tlast;

    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tid;

    modport slave (
        input  s0_tvalid, s0_tdata, s0_tlast, output s0_tready,
        input  s1_tvalid, s1_tdata, s1_tlast, output s1_tready,
        output c_tvalid,  c_tdata,  c_tlast,  input  c_tready,
        input  z_tvalid,  z_tdata,  z_tkeep,  z_tlast, output z_tready,
        output m_tvalid,  m_tdata,  m_tkeep,  m_tlast, m_tid, input m_tready
    );

    modport master (
        output s0_tvalid, s0_tdata, s0_tlast, input  s0_tready,
        output s1_tvalid, s1_tdata, s1_tlast, input  s1_tready,
        input  c_tvalid,  c_tdata,  c_tlast,  output c_tready,
        output z_tvalid,  z_tdata,  z_tkeep,  z_tlast, input z_tready,
        input  m_tvalid,  m_tdata,  m_tkeep,  m_tlast, m_tid, output m_tready
    );
endinterface

// File: rtl/gzip_packet_arbiter.sv
// Packet-granular round-robin share of one compressor between two requesters; output tagged with owner ID.
// Zero-latency combinational data paths; backpressure passes straight through, grants stall while the ID FIFO is full.
module gzip_packet_arbiter #(
    parameter int FIFO_EA = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    gzip_packet_arbiter_if.slave bus,
    output logic                 o_busy
);
    localparam int DEPTH = 1 << FIFO_EA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [FIFO_EA-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_EA-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_EA:0]   cnt_q, cnt_d;
    logic [DEPTH-1:0]   id_mem_q, id_mem_d;

    logic full, empty, push, push_id, pop;

    // Full is judged on the registered count so a same-cycle pop never frees a slot early.
    assign full  = (cnt_q == (FIFO_EA+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign pop   = bus.z_tvalid & bus.m_tready & bus.z_tlast & ~empty;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        push         = 1'b0;
        push_id      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!full) begin
                    if (bus.s0_tvalid && (!bus.s1_tvalid || last_grant_q)) begin
                        state_d      = GRANT0;
                        push         = 1'b1;
                        push_id      = 1'b0;
                        last_grant_d = 1'b0;
                    end else if (bus.s1_tvalid) begin
                        state_d      = GRANT1;
                        push         = 1'b1;
                        push_id      = 1'b1;
                        last_grant_d = 1'b1;
                    end
                end
            end
            GRANT0: if (bus.s0_tvalid && bus.c_tready && bus.s0_tlast) state_d = IDLE;
            GRANT1: if (bus.s1_tvalid && bus.c_tready && bus.s1_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        id_mem_d = id_mem_q;
        if (push) begin
            id_mem_d[wr_ptr_q] = push_id;
            wr_ptr_d           = wr_ptr_q + FIFO_EA'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + FIFO_EA'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (FIFO_EA+1)'(1);
            2'b01:   cnt_d = cnt_q - (FIFO_EA+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            id_mem_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            id_mem_q     <= id_mem_d;
        end
    end

    always_comb begin
        bus.s0_tready = 1'b0;
        bus.s1_tready = 1'b0;
        bus.c_tvalid  = 1'b0;
        bus.c_tdata   = '0;
        bus.c_tlast   = 1'b0;
        case (state_q)
            GRANT0: begin
                bus.c_tvalid  = bus.s0_tvalid;
                bus.c_tdata   = bus.s0_tdata;
                bus.c_tlast   = bus.s0_tlast;
                bus.s0_tready = bus.c_tready;
            end
            GRANT1: begin
                bus.c_tvalid  = bus.s1_tvalid;
                bus.c_tdata   = bus.s1_tdata;
                bus.c_tlast   = bus.s1_tlast;
                bus.s1_tready = bus.c_tready;
            end
            default: ;
        endcase
    end

    // Compressed output only moves once its owner is known, so nothing leaves untagged.
    assign bus.m_tvalid = bus.z_tvalid & ~empty;
    assign bus.z_tready = bus.m_tready & ~empty;
    assign bus.m_tdata  = bus.z_tdata;
    assign bus.m_tkeep  = bus.z_tkeep;
    assign bus.m_tlast  = bus.z_tlast;
    assign bus.m_tid    = id_mem_q[rd_ptr_q];

    assign o_busy = (state_q != IDLE) | ~empty;
endmodule
